framebuffer_readback: RTL and testbench
=======================================

// Module: framebuffer_readback
// PURPOSE
//  Reads one framebuffer row back out over the 8-bit RAM port and streams it to a UART byte transmitter.
//  It is the return path of the host's row-write command; the line format is identical, so captures can be replayed.
//  Wire format: 'L', two decimal row digits, 2*BYTES_PER_ROW uppercase hex chars (high nibble first), then 8'h0A.
//  It sits beside control_module on RAM port A (read-only use) and drives a debug/host UART transmitter.
// PARAMETERS
//  BYTES_PER_ROW  128  bytes per framebuffer row (64 px * RGB565); power of two
//  ROW_WIDTH      5    row index width (32 rows)
//  ADDR_WIDTH     12   RAM byte address width; must equal ROW_WIDTH + log2(BYTES_PER_ROW)
// PORTS
//  clk_in          in   1           single clock (clk_root domain)
//  reset           in   1           synchronous, active-high
//  start           in   1           1-cycle request; sampled only in IDLE
//  row_index       in   ROW_WIDTH   row to dump; latched on accepted start
//  busy            out  1           high from the cycle after an accepted start until done
//  done            out  1           1-cycle pulse after the final 8'h0A is handed to the transmitter
//  ram_address     out  ADDR_WIDTH  {row_latched, byte_index}
//  ram_clk_enable  out  1           read strobe; data is valid on ram_data_in 1 cycle later
//  ram_data_in     in   8           RAM read data
//  tx_data         out  8           byte to transmit; valid while tx_start is high
//  tx_start        out  1           1-cycle launch pulse
//  tx_busy         in   1           transmitter busy; rises no later than 1 cycle after tx_start
// BEHAVIOUR
//  Reset values: busy=0, done=0, tx_start=0, tx_data=0, ram_clk_enable=0, ram_address=0; FSM in IDLE.
//  Reset mid-operation aborts at once: no further tx_start or ram_clk_enable; the partial line is not completed.
//  FSM states: IDLE -> HDR -> TENS -> ONES -> FETCH -> WAIT_RAM -> HEX_HI -> HEX_LO -> (FETCH | EOL) -> DONE -> IDLE.
//  IDLE: start=1 latches row_index, clears byte_index, goes to HDR. start while busy is ignored (not queued).
//  Send rule (HDR/TENS/ONES/HEX_HI/HEX_LO/EOL):
//   - Fire when tx_busy=0 and no guard cycle is pending: tx_start=1 for one cycle with tx_data valid.
//   - The cycle after any tx_start is a guard cycle; no new send in it.
//   - Wait for tx_busy=0 before the next send.
//  Characters per state:
//   - HDR sends 8'h4C ('L').
//   - TENS sends "0"+row/10 and ONES sends "0"+row%10 (rows 0..31 -> "00".."31").
//  FETCH: ram_clk_enable=1 and ram_address={row,byte_index} for exactly one cycle.
//  WAIT_RAM: captures ram_data_in into a byte register; 2-cycle FETCH->capture latency.
//  Hex encoding:
//   - Nibble n<10 -> 8'h30+n; n>=10 -> 8'h41+n-10 ('A'..'F').
//   - HEX_HI sends the high nibble, HEX_LO the low nibble.
//  After HEX_LO:
//   - If byte_index==BYTES_PER_ROW-1, go to EOL.
//   - Otherwise increment byte_index (wraps naturally at width) and go to FETCH.
//   - The fetch overlaps the HEX_LO character's transmission.
//  EOL sends 8'h0A; DONE pulses done=1 for one cycle with busy still high; IDLE next cycle with busy=0.
//  Line length is exactly 3 + 2*BYTES_PER_ROW + 1 bytes (260 at defaults); RAM reads are exactly BYTES_PER_ROW.
//  ram_clk_enable never asserts outside FETCH; this block never writes RAM.
//  No address ever leaves the latched row: byte_index wraps only at line end.
// TESTING
//  1. RAM row 5 = 0x00..0x7F, start with row_index=5 -> tx stream "L05000102...7E7F\n".
//     Exactly 260 tx_start pulses, then one done pulse.
//  2. Row 31, all bytes 0xAB; tx_busy held high 20 cycles after each tx_start.
//     -> "L31ABAB...AB\n"; never two tx_start within a tx_busy window; 128 ram_clk_enable pulses.
//  3. tx_busy tied 0 -> tx_start spacing >=2 cycles.
//     Each ram_address {row,i} is followed by a captured byte equal to the RAM content at i.
//  4. start pulsed again at byte 40 of row 2 -> ignored.
//     Row-2 line completes unchanged; only one done pulse.
//  5. reset asserted after 100 bytes sent -> next cycle busy=0, tx_start=0, ram_clk_enable=0.
//     A fresh start for row 0 yields a complete "L00...\n".
//  6. Row 10, byte 0x9F at index 0 -> first chars 'L','1','0','9','F' (hex letters uppercase).

Source files
------------

// File: rtl/framebuffer_readback.sv
// framebuffer_readback
// Reads one framebuffer row from RAM port A (read-only) and streams it to a UART byte
// transmitter as a text line: 'L', two decimal row digits, two uppercase hex chars per byte
// (high nibble first), then 8'h0A. The line format matches the host's row-write command,
// so a captured line can be replayed as a write.
//
// Ports
//   clk_in          clock (clk_root domain)
//   reset           synchronous, active-high
//   start           1-cycle request, accepted only while idle
//   row_index       row to dump, latched on an accepted start
//   busy            high from the cycle after an accepted start until done
//   done            1-cycle pulse after the final 8'h0A has been launched
//   ram_address     {row, byte_index}
//   ram_clk_enable  read strobe; RAM data is valid on ram_data_in one cycle later
//   ram_data_in     RAM read data
//   tx_data         byte to transmit, valid while tx_start is high
//   tx_start        1-cycle launch pulse
//   tx_busy         transmitter busy; rises no later than one cycle after tx_start
//
// ADDR_WIDTH must equal ROW_WIDTH + log2(BYTES_PER_ROW).
module framebuffer_readback #(
    parameter int unsigned BYTES_PER_ROW = 128,
    parameter int unsigned ROW_WIDTH     = 5,
    parameter int unsigned ADDR_WIDTH    = 12
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ROW_WIDTH-1:0]  row_index,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_clk_enable,
    input  logic [7:0]            ram_data_in,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_busy
);

    localparam int unsigned IdxWidth = $clog2(BYTES_PER_ROW);
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(BYTES_PER_ROW - 1);

    typedef enum logic [3:0] {
        StIdle,
        StHdr,
        StTens,
        StOnes,
        StFetch,
        StWaitRam,
        StHexHi,
        StHexLo,
        StEol,
        StDone
    } state_e;

    state_e               state_q;
    logic [ROW_WIDTH-1:0] row_q;
    logic [IdxWidth-1:0]  byte_idx_q;
    logic [7:0]           byte_q;

    logic [IdxWidth-1:0]  idx_next;
    logic [7:0]           tens_char;
    logic [7:0]           ones_char;
    logic                 can_send;

    assign idx_next  = byte_idx_q + 1'b1;
    assign tens_char = 8'h30 + 8'(row_q / ROW_WIDTH'(10));
    assign ones_char = 8'h30 + 8'(row_q % ROW_WIDTH'(10));
    // A registered tx_start means a byte is launching this cycle; the transmitter may not
    // have raised tx_busy yet, so this cycle is the guard cycle and must not send.
    assign can_send  = !tx_busy && !tx_start;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};  // 'A' - 10
    endfunction

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q        <= StIdle;
            row_q          <= '0;
            byte_idx_q     <= '0;
            byte_q         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            ram_address    <= '0;
            ram_clk_enable <= 1'b0;
            tx_data        <= '0;
            tx_start       <= 1'b0;
        end else begin
            tx_start       <= 1'b0;
            ram_clk_enable <= 1'b0;
            done           <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        row_q      <= row_index;
                        byte_idx_q <= '0;
                        busy       <= 1'b1;
                        state_q    <= StHdr;
                    end
                end
                StHdr: begin
                    if (can_send) begin
                        tx_data  <= 8'h4C;
                        tx_start <= 1'b1;
                        state_q  <= StTens;
                    end
                end
                StTens: begin
                    if (can_send) begin
                        tx_data  <= tens_char;
                        tx_start <= 1'b1;
                        state_q  <= StOnes;
                    end
                end
                StOnes: begin
                    if (can_send) begin
                        tx_data        <= ones_char;
                        tx_start       <= 1'b1;
                        // Strobe is issued here so it is high for exactly the StFetch cycle.
                        ram_clk_enable <= 1'b1;
                        ram_address    <= {row_q, byte_idx_q};
                        state_q        <= StFetch;
                    end
                end
                StFetch: begin
                    state_q <= StWaitRam;
                end
                StWaitRam: begin
                    byte_q  <= ram_data_in;
                    state_q <= StHexHi;
                end
                StHexHi: begin
                    if (can_send) begin
                        tx_data  <= hex_char(byte_q[7:4]);
                        tx_start <= 1'b1;
                        state_q  <= StHexLo;
                    end
                end
                StHexLo: begin
                    if (can_send) begin
                        tx_data  <= hex_char(byte_q[3:0]);
                        tx_start <= 1'b1;
                        if (byte_idx_q == LastIdx) begin
                            state_q <= StEol;
                        end else begin
                            // Next fetch overlaps this character's transmission.
                            byte_idx_q     <= idx_next;
                            ram_clk_enable <= 1'b1;
                            ram_address    <= {row_q, idx_next};
                            state_q        <= StFetch;
                        end
                    end
                end
                StEol: begin
                    if (can_send) begin
                        tx_data  <= 8'h0A;
                        tx_start <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    // First cycle: the 8'h0A launches; second cycle: done pulses with busy high.
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_framebuffer_readback.sv
// Self-checking bench for framebuffer_readback: random RAM rows and transmitter busy
// lengths, with the expected text line built directly from the wire format.
module tb_framebuffer_readback;

    localparam int BPR      = 128;
    localparam int RW       = 5;
    localparam int AW       = 12;
    localparam int LINE_LEN = 3 + 2 * BPR + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [RW-1:0] row_index;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_address;
    logic          ram_clk_enable;
    logic [7:0]    ram_data_in = 8'h00;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy = 1'b0;

    always #5 clk = ~clk;

    framebuffer_readback #(
        .BYTES_PER_ROW(BPR),
        .ROW_WIDTH    (RW),
        .ADDR_WIDTH   (AW)
    ) dut (
        .clk_in        (clk),
        .reset         (reset),
        .start         (start),
        .row_index     (row_index),
        .busy          (busy),
        .done          (done),
        .ram_address   (ram_address),
        .ram_clk_enable(ram_clk_enable),
        .ram_data_in   (ram_data_in),
        .tx_data       (tx_data),
        .tx_start      (tx_start),
        .tx_busy       (tx_busy)
    );

    logic [7:0] mem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor state
    logic [7:0]    tx_q[$];
    int            addr_q[$];
    int            done_cnt = 0;
    int            tx_at_done = -1;
    int            busy_at_done = 0;
    int            busy_after_done = -1;
    logic          done_prev = 1'b0;
    int            cyc = 0;
    int            last_tx_cyc = -100;
    int            spacing_viol = 0;
    int            busy_viol = 0;
    int            stray_rd = 0;
    int            hold = 0;
    int            busy_cnt = 0;
    logic          pend = 1'b0;
    logic [AW-1:0] pend_addr = '0;

    always @(negedge clk) begin
        cyc++;
        if (tx_start) begin
            if (tx_busy) busy_viol++;
            if (cyc - last_tx_cyc < 2) spacing_viol++;
            last_tx_cyc = cyc;
            tx_q.push_back(tx_data);
        end
        if (tx_start && hold > 0) busy_cnt = hold;
        else if (busy_cnt > 0) busy_cnt--;
        tx_busy = (busy_cnt > 0);
        if (ram_clk_enable) begin
            addr_q.push_back(int'(ram_address));
            if (!busy) stray_rd++;
        end
        pend      = ram_clk_enable;
        pend_addr = ram_address;
        if (done_prev) busy_after_done = int'(busy);
        if (done) begin
            done_cnt++;
            tx_at_done   = tx_q.size();
            busy_at_done = int'(busy);
        end
        done_prev = done;
    end

    // Synchronous-read RAM; garbage on the bus whenever no read was issued.
    always @(posedge clk) ram_data_in <= pend ? mem[pend_addr] : 8'($urandom);

    function automatic string expected_line(input int row);
        string hd = "0123456789ABCDEF";
        string s;
        logic [7:0] b;
        s = $sformatf("L%0d%0d", row / 10, row % 10);
        for (int i = 0; i < BPR; i++) begin
            b = mem[row * BPR + i];
            s = {s, hd.substr(int'(b[7:4]), int'(b[7:4])), hd.substr(int'(b[3:0]), int'(b[3:0]))};
        end
        s = {s, "\n"};
        return s;
    endfunction

    task automatic clear_mon();
        tx_q.delete();
        addr_q.delete();
        done_cnt        = 0;
        tx_at_done      = -1;
        busy_at_done    = 0;
        busy_after_done = -1;
        spacing_viol    = 0;
        busy_viol       = 0;
        stray_rd        = 0;
    endtask

    task automatic fill_row(input int row);
        for (int i = 0; i < BPR; i++) mem[row * BPR + i] = 8'($urandom);
    endtask

    task automatic start_line(input int row);
        @(negedge clk);
        start     = 1'b1;
        row_index = RW'(row);
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit, input bit inject);
        int c        = 0;
        bit inj_done = 1'b0;
        bit inj_act  = 1'b0;
        while (done_cnt == 0 && c < limit) begin
            @(negedge clk);
            c++;
            if (inj_act) begin
                start   = 1'b0;
                inj_act = 1'b0;
            end else if (inject && !inj_done && tx_q.size() >= 40) begin
                start     = 1'b1;
                row_index = RW'(7);
                inj_done  = 1'b1;
                inj_act   = 1'b1;
            end
        end
        start = 1'b0;
        if (done_cnt == 0) check({tag, ":timeout"}, done_cnt, 1);
        repeat (8) @(negedge clk);
    endtask

    task automatic verify_line(input string tag, input int row);
        string      exp;
        logic [7:0] e;
        int         e0;
        exp = expected_line(row);
        check({tag, ":len"}, tx_q.size(), exp.len());
        for (int i = 0; i < exp.len() && i < tx_q.size(); i++) begin
            e  = exp[i];
            e0 = n_errors;
            check($sformatf("%s:char%0d", tag, i), 32'(tx_q[i]), 32'(e));
            if (n_errors != e0) break;
        end
        check({tag, ":reads"}, addr_q.size(), BPR);
        for (int i = 0; i < addr_q.size(); i++) begin
            e0 = n_errors;
            check($sformatf("%s:addr%0d", tag, i), addr_q[i], row * BPR + i);
            if (n_errors != e0) break;
        end
        check({tag, ":done_cnt"}, done_cnt, 1);
        check({tag, ":tx_at_done"}, tx_at_done, LINE_LEN);
        check({tag, ":busy_at_done"}, busy_at_done, 1);
        check({tag, ":busy_after_done"}, busy_after_done, 0);
        check({tag, ":spacing"}, spacing_viol, 0);
        check({tag, ":tx_busy_overlap"}, busy_viol, 0);
        check({tag, ":stray_read"}, stray_rd, 0);
    endtask

    task automatic run_line(input string tag, input int row, input int h, input bit inject);
        hold = h;
        clear_mon();
        start_line(row);
        wait_done(tag, 20000, inject);
        verify_line(tag, row);
    endtask

    initial begin
        string pre;
        string got5;
        int    r;
        int    c;

        reset     = 1'b1;
        start     = 1'b0;
        row_index = '0;
        for (int a = 0; a < (1 << AW); a++) mem[a] = 8'($urandom);
        repeat (3) @(negedge clk);
        check("rst:busy", 32'(busy), 0);
        check("rst:done", 32'(done), 0);
        check("rst:tx_start", 32'(tx_start), 0);
        check("rst:tx_data", 32'(tx_data), 0);
        check("rst:ram_clk_enable", 32'(ram_clk_enable), 0);
        check("rst:ram_address", 32'(ram_address), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Ramp row
        for (int i = 0; i < BPR; i++) mem[5 * BPR + i] = 8'(i);
        run_line("t1", 5, 3, 1'b0);

        // Constant row, slow transmitter
        for (int i = 0; i < BPR; i++) mem[31 * BPR + i] = 8'hAB;
        run_line("t2", 31, 20, 1'b0);

        // Transmitter never busy
        r = int'($urandom_range(0, 31));
        fill_row(r);
        run_line("t3", r, 0, 1'b0);

        // Second start mid-line is ignored
        fill_row(2);
        run_line("t4", 2, 1, 1'b1);

        // Reset mid-line, then a fresh line
        fill_row(9);
        hold = 2;
        clear_mon();
        start_line(9);
        c = 0;
        while (tx_q.size() < 100 && c < 5000) begin
            @(negedge clk);
            c++;
        end
        check("t5:progress", 32'(tx_q.size() >= 100), 1);
        reset = 1'b1;
        @(negedge clk);
        check("t5:busy", 32'(busy), 0);
        check("t5:tx_start", 32'(tx_start), 0);
        check("t5:ram_clk_enable", 32'(ram_clk_enable), 0);
        reset = 1'b0;
        clear_mon();
        repeat (6) @(negedge clk);
        check("t5:quiet_tx", tx_q.size(), 0);
        check("t5:quiet_rd", addr_q.size(), 0);
        fill_row(0);
        run_line("t5b", 0, 2, 1'b0);

        // Hex letters are uppercase
        fill_row(10);
        mem[10 * BPR] = 8'h9F;
        run_line("t6", 10, 0, 1'b0);
        pre  = "L109F";
        got5 = "";
        for (int i = 0; i < 5 && i < tx_q.size(); i++) got5 = {got5, string'(tx_q[i])};
        check("t6:prefix", 32'(got5 == pre), 1);

        // Random rows and transmitter speeds
        for (int k = 0; k < 5; k++) begin
            r = int'($urandom_range(0, 31));
            fill_row(r);
            run_line($sformatf("rnd%0d", k), r, int'($urandom_range(0, 4)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
